// File: rtl/pass_pkg.sv
// Shared constants and helpers for the pass-through arbiter slice.
// Round-robin selection in pass_arbiter is enabled by defining PASS_ARB_RR_EN.
package pass_pkg;

  localparam int PASS_WIDTH    = 8;
  localparam int PASS_NPORT    = 4;
  localparam int PASS_DEPTH    = 4;
  localparam int PASS_MAX_PORT = 16;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // True when exactly one bit is set. Callers zero-extend to PASS_MAX_PORT.
  function automatic logic is_onehot(input logic [PASS_MAX_PORT-1:0] vec);
    return (vec != '0) && ((vec & (vec - PASS_MAX_PORT'(1))) == '0);
  endfunction

endpackage

// File: rtl/pass_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// When empty, o_Data keeps showing the last word that was popped.
module pass_fifo
  import pass_pkg::*;
#(
  parameter int WIDTH = PASS_WIDTH,
  parameter int DEPTH = PASS_DEPTH
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   i_Push,
  input  logic [WIDTH-1:0]       i_Push_Data,
  input  logic                   i_Pop,
  output logic                   o_Valid,
  output logic [WIDTH-1:0]       o_Data,
  output logic [clog2(DEPTH):0]  o_Count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] last_q;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = i_Pop && (count != '0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok = i_Push && ((count != CW'(DEPTH)) || pop_ok);

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= i_Push_Data;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign o_Valid = (count != '0);
  assign o_Data  = o_Valid ? mem[rd_ptr] : last_q;
  assign o_Count = count;

endmodule

// File: rtl/pass_arbiter.sv
// Credit-based grant arbiter and collector for a row of pass-through stages.
// PASS_ARB_RR_EN selects round-robin winners; otherwise lowest index wins.
module pass_arbiter
  import pass_pkg::*;
#(
  parameter int WIDTH = PASS_WIDTH,
  parameter int NPORT = PASS_NPORT,
  parameter int DEPTH = PASS_DEPTH
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic [NPORT-1:0]        i_Req,
  output logic [NPORT-1:0]        o_Grant,
  input  logic [NPORT-1:0]        i_Valid,
  input  logic [NPORT*WIDTH-1:0]  i_Data,
  output logic                    o_Valid,
  output logic [WIDTH-1:0]        o_Data,
  input  logic                    i_Ready,
  output logic [clog2(DEPTH):0]   o_Count,
  output logic                    o_Err
);

  localparam int CW = clog2(DEPTH) + 1;
  localparam int PW = clog2(NPORT);

  logic                     pend;
  logic [NPORT-1:0]         grant_q;
  logic                     err_q;
  logic [NPORT-1:0]         win;
  logic [CW:0]              occ;
  logic                     credit;
  logic [PASS_MAX_PORT-1:0] valid_ext;
  logic                     bad;
  logic                     push;
  logic [WIDTH-1:0]         cap_data;

`ifdef PASS_ARB_RR_EN
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] sel;
  int            rr_idx;

  // Scan downward so the smallest offset from rr_ptr is the last one written.
  always_comb begin
    win     = '0;
    win_idx = '0;
    sel     = '0;
    rr_idx  = 0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      rr_idx = int'(rr_ptr) + i;
      if (rr_idx >= NPORT) rr_idx = rr_idx - NPORT;
      sel = PW'(rr_idx);
      if (i_Req[sel]) begin
        win      = '0;
        win[sel] = 1'b1;
        win_idx  = sel;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      rr_ptr <= '0;
    end else if (|o_Grant) begin
      rr_ptr <= (int'(win_idx) == NPORT - 1) ? '0 : win_idx + PW'(1);
    end
  end
`else
  always_comb begin
    win = '0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (i_Req[i]) begin
        win    = '0;
        win[i] = 1'b1;
      end
    end
  end
`endif

  // Credit counts words already stored plus the one still in flight;
  // a pop this cycle is deliberately not counted.
  assign occ     = {1'b0, o_Count} + {{CW{1'b0}}, pend};
  assign credit  = occ < (CW + 1)'(DEPTH);
  assign o_Grant = (!Reset && credit) ? win : '0;

  always_comb begin
    valid_ext             = '0;
    valid_ext[NPORT-1:0]  = i_Valid;
  end

  always_comb begin
    cap_data = '0;
    for (int k = 0; k < NPORT; k++) begin
      if (i_Valid[k]) cap_data = cap_data | i_Data[k*WIDTH +: WIDTH];
    end
  end

  // i_Valid only matters in the cycle after a grant; it must echo that grant exactly.
  assign bad  = pend && (!is_onehot(valid_ext) || (i_Valid != grant_q));
  assign push = pend && !bad;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pend    <= 1'b0;
      grant_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pend    <= |o_Grant;
      grant_q <= o_Grant;
      if (bad) err_q <= 1'b1;
    end
  end

  assign o_Err = err_q;

  // Output handshake: a word leaves when o_Valid and i_Ready are both high at
  // the rising edge; o_Valid/o_Data never depend combinationally on i_Ready.
  pass_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK         (CLK),
    .Reset       (Reset),
    .i_Push      (push),
    .i_Push_Data (cap_data),
    .i_Pop       (i_Ready),
    .o_Valid     (o_Valid),
    .o_Data      (o_Data),
    .o_Count     (o_Count)
  );

  a_grant_onehot0 : assert property (@(posedge CLK) disable iff (Reset) $onehot0(o_Grant));
  a_no_overrun    : assert property (@(posedge CLK) disable iff (Reset)
                                     (int'(o_Count) + int'(pend)) <= DEPTH);

endmodule

// File: tb/tb_pass_arbiter.sv
// Self-checking bench for pass_arbiter with a behavioural row of pass-through stages.
module tb_pass_arbiter;

  localparam int WIDTH = 8;
  localparam int NPORT = 4;
  localparam int DEPTH = 4;

  logic                   CLK = 1'b0;
  logic                   Reset = 1'b1;
  logic [NPORT-1:0]       i_Req = '0;
  logic [NPORT-1:0]       o_Grant;
  logic [NPORT-1:0]       i_Valid = '0;
  logic [NPORT*WIDTH-1:0] i_Data = '0;
  logic                   o_Valid;
  logic [WIDTH-1:0]       o_Data;
  logic                   i_Ready = 1'b0;
  logic [2:0]             o_Count;
  logic                   o_Err;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic             stage_auto = 1'b1;
  logic [WIDTH-1:0] next_data = 8'h01;

  logic [NPORT-1:0] s_grant;
  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic [2:0]       s_count;
  logic             s_err;

  pass_arbiter #(
    .WIDTH (WIDTH),
    .NPORT (NPORT),
    .DEPTH (DEPTH)
  ) dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .i_Req   (i_Req),
    .o_Grant (o_Grant),
    .i_Valid (i_Valid),
    .i_Data  (i_Data),
    .o_Valid (o_Valid),
    .o_Data  (o_Data),
    .i_Ready (i_Ready),
    .o_Count (o_Count),
    .o_Err   (o_Err)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "watchdog expired");
  end

  // One cycle: sample outputs at negedge, pop scoreboard, then act as the stages.
  task automatic tick();
    logic [WIDTH-1:0] exp;
    @(negedge CLK);
    s_grant = o_Grant;
    s_valid = o_Valid;
    s_data  = o_Data;
    s_count = o_Count;
    s_err   = o_Err;
    if (!Reset && o_Valid && i_Ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got data=%h, required no output", o_Data);
      end else begin
        exp = exp_q.pop_front();
        if (o_Data !== exp) begin
          errors++;
          $display("FAIL pop_data: got %h, required %h", o_Data, exp);
        end
      end
    end
    @(posedge CLK);
    #1;
    if (stage_auto) begin
      i_Valid = s_grant;
      i_Data  = '0;
      for (int k = 0; k < NPORT; k++) begin
        if (s_grant[k]) begin
          i_Data[k*WIDTH +: WIDTH] = next_data;
          exp_q.push_back(next_data);
          next_data++;
        end
      end
    end
  endtask

  task automatic do_reset(input int n);
    Reset      = 1'b1;
    i_Req      = '0;
    i_Ready    = 1'b0;
    i_Valid    = '0;
    i_Data     = '0;
    stage_auto = 1'b1;
    repeat (n) tick();
    Reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    Reset   = 1'b1;
    i_Req   = 4'b1111;
    i_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (s_grant !== 4'b0000) begin
        errors++;
        $display("FAIL reset_grant_forced: got %b, required 0000", s_grant);
      end
    end
    Reset   = 1'b0;
    i_Req   = '0;
    i_Ready = 1'b0;
    exp_q.delete();
    tick();
    checks++;
    if ({s_grant, s_valid, s_data, s_count, s_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got grant=%b valid=%b data=%h count=%0d err=%b, required all 0",
               s_grant, s_valid, s_data, s_count, s_err);
    end
  endtask

  task automatic test_single_port();
    do_reset(1);
    i_Ready   = 1'b1;
    next_data = 8'hA5;
    i_Req     = 4'b0100;
    tick();
    checks++;
    if (s_grant !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant: got %b, required 0100", s_grant);
    end
    i_Req = '0;
    tick();
    checks++;
    if (s_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early_valid: got %b, required 0", s_valid);
    end
    tick();
    checks++;
    if (s_valid !== 1'b1 || s_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_output: got valid=%b data=%h, required valid=1 data=a5", s_valid, s_data);
    end
    tick();
    checks++;
    if (s_count !== 3'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_drain: got count=%0d pending=%0d, required 0 and 0", s_count, exp_q.size());
    end
  endtask

  task automatic test_round_robin();
    logic [NPORT-1:0] exp_g;
    int               n;
    do_reset(1);
    i_Ready   = 1'b1;
    next_data = 8'h10;
    i_Req     = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
`ifdef PASS_ARB_RR_EN
      exp_g = 4'(1 << (i % 4));
`else
      exp_g = 4'b0001;
`endif
      checks++;
      if (s_grant !== exp_g) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %b, required %b", i, s_grant, exp_g);
      end
    end
    i_Req = '0;
    n = 0;
    do begin
      tick();
      n++;
    end while ((exp_q.size() != 0 || s_count != 0) && n < 12);
    checks++;
    if (exp_q.size() != 0 || s_count !== 3'd0) begin
      errors++;
      $display("FAIL rr_drain: got pending=%0d count=%0d, required 0 and 0", exp_q.size(), s_count);
    end
  endtask

  task automatic test_backpressure();
    int ngr;
    int n;
    do_reset(1);
    i_Ready   = 1'b0;
    next_data = 8'h01;
    i_Req     = 4'b0001;
    ngr = 0;
    repeat (8) begin
      tick();
      if (s_grant != '0) ngr++;
    end
    checks++;
    if (ngr != 4 || s_grant !== 4'b0000) begin
      errors++;
      $display("FAIL bp_grants: got %0d grants last=%b, required 4 grants last=0000", ngr, s_grant);
    end
    checks++;
    if (s_count !== 3'd4 || s_valid !== 1'b1 || s_data !== 8'h01) begin
      errors++;
      $display("FAIL bp_full: got count=%0d valid=%b head=%h, required 4 1 01", s_count, s_valid, s_data);
    end
    i_Ready = 1'b1;
    tick();
    checks++;
    if (s_grant !== 4'b0000 || s_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_pop_no_credit: got grant=%b valid=%b, required 0000 1", s_grant, s_valid);
    end
    tick();
    checks++;
    if (s_grant !== 4'b0001 || s_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_resume: got grant=%b valid=%b, required 0001 1", s_grant, s_valid);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (s_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_pop_rate[%0d]: got valid=%b, required 1", i, s_valid);
      end
    end
    i_Req = '0;
    n = 0;
    do begin
      tick();
      n++;
    end while ((exp_q.size() != 0 || s_count != 0) && n < 12);
    checks++;
    if (exp_q.size() != 0 || s_count !== 3'd0) begin
      errors++;
      $display("FAIL bp_drain: got pending=%0d count=%0d, required 0 and 0", exp_q.size(), s_count);
    end
  endtask

  task automatic test_protocol_error();
    logic [WIDTH-1:0] dropped;
    do_reset(1);
    i_Ready   = 1'b0;
    next_data = 8'h40;
    i_Req     = 4'b0001;
    tick();
    stage_auto = 1'b0;
    i_Valid    = 4'b0011;
    i_Data     = {8'h00, 8'h00, 8'h41, 8'h40};
    dropped    = exp_q.pop_back();
    i_Req      = '0;
    tick();
    i_Valid = '0;
    checks++;
    if (s_err !== 1'b0) begin
      errors++;
      $display("FAIL err_early: got %b, required 0", s_err);
    end
    tick();
    checks++;
    if (s_err !== 1'b1 || s_count !== 3'd0) begin
      errors++;
      $display("FAIL err_multi_valid: got err=%b count=%0d, required 1 0 (dropped %h)", s_err, s_count, dropped);
    end
    stage_auto = 1'b1;
    i_Req      = 4'b0001;
    tick();
    i_Req = '0;
    tick();
    tick();
    checks++;
    if (s_err !== 1'b1 || s_count !== 3'd1) begin
      errors++;
      $display("FAIL err_sticky: got err=%b count=%0d, required 1 1", s_err, s_count);
    end
    do_reset(1);
    tick();
    checks++;
    if (s_err !== 1'b0) begin
      errors++;
      $display("FAIL err_reset_clear: got %b, required 0", s_err);
    end
    i_Req = 4'b0010;
    tick();
    stage_auto = 1'b0;
    i_Valid    = 4'b0100;
    i_Data     = {8'h00, 8'h55, 8'h00, 8'h00};
    exp_q.delete();
    i_Req      = '0;
    tick();
    i_Valid = '0;
    tick();
    checks++;
    if (s_err !== 1'b1 || s_count !== 3'd0) begin
      errors++;
      $display("FAIL err_wrong_port: got err=%b count=%0d, required 1 0", s_err, s_count);
    end
    stage_auto = 1'b1;
  endtask

  task automatic test_mid_reset();
    do_reset(1);
    i_Ready   = 1'b0;
    next_data = 8'h77;
    i_Req     = 4'b0001;
    tick();
    stage_auto = 1'b0;
    exp_q.delete();
    Reset = 1'b1;
    tick();
    checks++;
    if (s_grant !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_grant: got %b, required 0000", s_grant);
    end
    Reset = 1'b0;
    i_Req = '0;
    tick();
    i_Valid    = '0;
    stage_auto = 1'b1;
    tick();
    checks++;
    if (s_count !== 3'd0 || s_valid !== 1'b0 || s_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: got count=%0d valid=%b err=%b, required 0 0 0", s_count, s_valid, s_err);
    end
    tick();
    checks++;
    if (s_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_err: got %b, required 0", s_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_protocol_error();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
